// File: rtl/dmem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : dmem_copy_engine
// Purpose  : Byte-wise block copy / block fill initiator for the data memory.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_copy_engine #(
    parameter int ADDRESS_LINE = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ADDRESS_LINE-1:0] src_addr,
    input  logic [ADDRESS_LINE-1:0] dst_addr,
    input  logic [ADDRESS_LINE-1:0] length,
    input  logic [7:0]              fill_value,
    input  logic [7:0]              mem_read_data,
    output logic [ADDRESS_LINE-1:0] mem_address,
    output logic [7:0]              mem_write_data,
    output logic                    mem_write,
    output logic                    mem_read,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic                    r_mode;
    logic [ADDRESS_LINE-1:0] r_src;
    logic [ADDRESS_LINE-1:0] r_dst;
    logic [ADDRESS_LINE-1:0] r_len;
    logic [7:0]              r_fill;
    logic [7:0]              r_data;
    logic [ADDRESS_LINE:0]   r_idx;

    logic [ADDRESS_LINE:0]   w_idx_next;
    logic                    w_last;
    logic [ADDRESS_LINE-1:0] w_src_ptr;
    logic [ADDRESS_LINE-1:0] w_dst_ptr;

    // Index is one bit wider than the length so i+1 never aliases to zero.
    assign w_idx_next = r_idx + {{ADDRESS_LINE{1'b0}}, 1'b1};
    assign w_last     = (w_idx_next == {1'b0, r_len});
    assign w_src_ptr  = r_src + r_idx[ADDRESS_LINE-1:0];
    assign w_dst_ptr  = r_dst + r_idx[ADDRESS_LINE-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_fill  <= '0;
            r_data  <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_src  <= src_addr;
                        r_dst  <= dst_addr;
                        r_len  <= length;
                        r_fill <= fill_value;
                        r_idx  <= '0;
                        if (length == '0)
                            r_state <= S_DONE;
                        else if (mode)
                            r_state <= S_WRITE;
                        else
                            r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_data  <= mem_read_data;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_idx <= w_idx_next;
                    if (w_last)
                        r_state <= S_DONE;
                    else if (r_mode)
                        r_state <= S_WRITE;
                    else
                        r_state <= S_READ;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory outputs decode only from registered state, never from start.
    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (r_state)
            S_READ: begin
                mem_read    = 1'b1;
                mem_address = w_src_ptr;
                busy        = 1'b1;
            end
            S_WRITE: begin
                mem_write      = 1'b1;
                mem_address    = w_dst_ptr;
                mem_write_data = r_mode ? r_fill : r_data;
                busy           = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire
